main_ram_mc: RTL

- Parametrised successor to the two-bank VERA main RAM. Multi-channel, multi-bank video RAM with nibble write masks and registered reads.
- NUM_CH requesters (CPU port, layer fetch, sprite fetch, ...) share NUM_BANKS independent single-port banks.
- Each bank has its own round-robin arbiter, so accesses to different banks in the same cycle all proceed.
- Read data returns to the granted channel one cycle after grant, tagged by a per-channel valid.

---
 rtl/main_ram_mc.sv | 132 +++++++++++++
 1 files changed

// File: rtl/main_ram_mc.sv
// Multi-channel, multi-bank video RAM with nibble write masks and registered reads.
// Every bank has its own round-robin arbiter, so channels hitting different banks proceed in parallel.
module main_ram_mc #(
  parameter int NUM_CH    = 2,
  parameter int NUM_BANKS = 2,
  parameter int ADDR_W    = 15,
  parameter int DATA_W    = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            ch_req,
  input  logic [NUM_CH-1:0]            ch_write,
  input  logic [NUM_CH*ADDR_W-1:0]     ch_addr,
  input  logic [NUM_CH*DATA_W-1:0]     ch_wrdata,
  input  logic [NUM_CH*(DATA_W/4)-1:0] ch_wrnibblesel,
  output logic [NUM_CH-1:0]            ch_ack,
  output logic [NUM_CH*DATA_W-1:0]     ch_rddata,
  output logic [NUM_CH-1:0]            ch_rdvalid
);

  localparam int NIB_W     = DATA_W / 4;
  localparam int BANK_BITS = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0;
  localparam int BB1       = (BANK_BITS > 0) ? BANK_BITS : 1;
  localparam int WORD_W    = ADDR_W - BANK_BITS;
  localparam int DEPTH     = 2 ** WORD_W;
  localparam int CHB       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [ADDR_W-1:0] w_chAddr  [NUM_CH];
  logic [WORD_W-1:0] w_chWord  [NUM_CH];
  logic [BB1-1:0]    w_chBank  [NUM_CH];
  logic [DATA_W-1:0] w_chWdata [NUM_CH];
  logic [NIB_W-1:0]  w_chSel   [NUM_CH];

  logic              w_gntValid  [NUM_BANKS];
  logic [CHB-1:0]    w_gntCh     [NUM_BANKS];
  logic              w_bankWe    [NUM_BANKS];
  logic              w_bankRe    [NUM_BANKS];
  logic [WORD_W-1:0] w_bankWord  [NUM_BANKS];
  logic [DATA_W-1:0] w_bankWdata [NUM_BANKS];
  logic [NIB_W-1:0]  w_bankSel   [NUM_BANKS];

  logic [CHB-1:0]    r_ptr      [NUM_BANKS];
  logic [DATA_W-1:0] r_mem      [NUM_BANKS][DEPTH];
  logic [DATA_W-1:0] r_bankDout [NUM_BANKS];
  logic [BB1-1:0]    r_rdBank   [NUM_CH];
  logic [DATA_W-1:0] r_hold     [NUM_CH];
  logic [NUM_CH-1:0] r_rdvalid;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_chAddr[i]  = ch_addr[i*ADDR_W +: ADDR_W];
      w_chWord[i]  = w_chAddr[i][WORD_W-1:0];
      w_chBank[i]  = BB1'(w_chAddr[i] >> WORD_W);
      w_chWdata[i] = ch_wrdata[i*DATA_W +: DATA_W];
      w_chSel[i]   = ch_wrnibblesel[i*NIB_W +: NIB_W];
    end
  end

  // Search upward from each bank's pointer; reset suppresses every grant.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_gntValid[b] = 1'b0;
      w_gntCh[b]    = '0;
      for (int k = 0; k < NUM_CH; k++) begin
        int idx;
        idx = (int'(r_ptr[b]) + k) % NUM_CH;
        if (!w_gntValid[b] && rst_n && ch_req[idx] && (w_chBank[idx] == BB1'(b))) begin
          w_gntValid[b] = 1'b1;
          w_gntCh[b]    = CHB'(idx);
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ch_ack[i] = 1'b0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (w_gntValid[b] && (w_gntCh[b] == CHB'(i))) ch_ack[i] = 1'b1;
      end
    end
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_bankWe[b]    = w_gntValid[b] && ch_write[w_gntCh[b]];
      w_bankRe[b]    = w_gntValid[b] && !ch_write[w_gntCh[b]];
      w_bankWord[b]  = w_chWord[w_gntCh[b]];
      w_bankWdata[b] = w_chWdata[w_gntCh[b]];
      w_bankSel[b]   = w_chSel[w_gntCh[b]];
    end
  end

  // Bank storage is never reset so it maps onto plain block RAM.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (w_bankWe[b]) begin
        for (int k = 0; k < NIB_W; k++) begin
          if (w_bankSel[b][k]) r_mem[b][w_bankWord[b]][4*k +: 4] <= w_bankWdata[b][4*k +: 4];
        end
      end
      if (w_bankRe[b]) r_bankDout[b] <= r_mem[b][w_bankWord[b]];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rdvalid <= '0;
      for (int b = 0; b < NUM_BANKS; b++) r_ptr[b] <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_rdBank[i] <= '0;
        r_hold[i]   <= '0;
      end
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (w_gntValid[b]) r_ptr[b] <= CHB'((int'(w_gntCh[b]) + 1) % NUM_CH);
      end
      for (int i = 0; i < NUM_CH; i++) begin
        r_rdvalid[i] <= ch_ack[i] && !ch_write[i];
        if (ch_ack[i] && !ch_write[i]) r_rdBank[i] <= w_chBank[i];
        if (r_rdvalid[i]) r_hold[i] <= r_bankDout[r_rdBank[i]];
      end
    end
  end

  // A bank's output register may be reused by another channel later, so each channel keeps a copy.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ch_rddata[i*DATA_W +: DATA_W] = r_rdvalid[i] ? r_bankDout[r_rdBank[i]] : r_hold[i];
    end
  end

  assign ch_rdvalid = r_rdvalid;

endmodule
